// File: rtl/tpu_act_row_loader.sv
// rtl/tpu_act_row_loader.sv - fetches activation rows over a read bus and writes packed rows to the buffer
module tpu_act_row_loader #(
    parameter int ARRAY_SIZE      = 8,
    parameter int ACT_BITS        = 16,
    parameter int MAX_K           = 256,
    parameter int ADDR_WIDTH      = 16,
    parameter int BUS_WIDTH       = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [ADDR_WIDTH-1:0]            cmd_base_addr,
    input  logic [$clog2(MAX_K):0]           cmd_rows,
    input  logic                             cmd_swap,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    input  logic                             mem_rsp_valid,
    output logic                             mem_rsp_ready,
    input  logic [BUS_WIDTH-1:0]             mem_rsp_data,
    output logic                             unified_wr_en,
    output logic [ADDR_WIDTH-1:0]            unified_wr_addr,
    output logic [ARRAY_SIZE*ACT_BITS-1:0]   unified_wr_data,
    output logic                             swap_banks,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(MAX_K):0]           rows_loaded
);
    localparam int BPR  = ARRAY_SIZE * ACT_BITS / BUS_WIDTH;
    localparam int RW   = $clog2(MAX_K) + 1;
    localparam int QW   = $clog2(MAX_K * BPR) + 1;
    localparam int OW   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BW   = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int ROWW = ARRAY_SIZE * ACT_BITS;

    typedef enum logic [1:0] {IDLE, LOAD, SWAP, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] base;
    logic                  swap_flag;
    logic [RW-1:0]         total_rows;
    logic [RW-1:0]         rows_clamped;
    logic [QW-1:0]         req_issued;
    logic [QW-1:0]         req_total;
    logic [OW-1:0]         outstanding;
    logic [BW-1:0]         beat_cnt;
    logic [ROWW-1:0]       row_buf;
    logic [ROWW-1:0]       row_next;
    logic                  done_q;
    logic                  req_hs;
    logic                  rsp_hs;
    logic                  last_beat;

    assign rows_clamped = (cmd_rows > RW'(MAX_K)) ? RW'(MAX_K) : cmd_rows;
    assign req_total    = QW'(total_rows) * QW'(BPR);
    assign last_beat    = (beat_cnt == BW'(BPR - 1));

    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign swap_banks    = (state == SWAP);
    assign done          = done_q;
    assign mem_req_valid = (state == LOAD) && (req_issued < req_total) &&
                           (outstanding < OW'(MAX_OUTSTANDING));
    assign mem_req_addr  = base + ADDR_WIDTH'(req_issued);
    assign mem_rsp_ready = (state == LOAD) && (outstanding != '0);
    assign req_hs        = mem_req_valid && mem_req_ready;
    assign rsp_hs        = mem_rsp_valid && mem_rsp_ready;

    // The incoming beat is merged combinationally so the last beat goes straight into the write register.
    always_comb begin
        row_next = row_buf;
        row_next[int'(beat_cnt) * BUS_WIDTH +: BUS_WIDTH] = mem_rsp_data;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_valid) state_next = (rows_clamped == '0) ? DONE : LOAD;
            LOAD: if (unified_wr_en && (rows_loaded == total_rows))
                      state_next = swap_flag ? SWAP : DONE;
            SWAP: state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            base            <= '0;
            swap_flag       <= 1'b0;
            total_rows      <= '0;
            req_issued      <= '0;
            outstanding     <= '0;
            beat_cnt        <= '0;
            row_buf         <= '0;
            done_q          <= 1'b0;
            unified_wr_en   <= 1'b0;
            unified_wr_addr <= '0;
            unified_wr_data <= '0;
            rows_loaded     <= '0;
        end else begin
            state         <= state_next;
            done_q        <= (state == DONE);
            unified_wr_en <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    base        <= cmd_base_addr;
                    swap_flag   <= cmd_swap;
                    total_rows  <= rows_clamped;
                    rows_loaded <= '0;
                    req_issued  <= '0;
                    outstanding <= '0;
                    beat_cnt    <= '0;
                end
            end else if (state == LOAD) begin
                if (req_hs) req_issued <= req_issued + 1'b1;
                if (req_hs && !rsp_hs)      outstanding <= outstanding + 1'b1;
                else if (!req_hs && rsp_hs) outstanding <= outstanding - 1'b1;
                if (rsp_hs) begin
                    if (last_beat) begin
                        unified_wr_en   <= 1'b1;
                        unified_wr_data <= row_next;
                        unified_wr_addr <= ADDR_WIDTH'(rows_loaded);
                        rows_loaded     <= rows_loaded + 1'b1;
                        beat_cnt        <= '0;
                    end else begin
                        row_buf  <= row_next;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tpu_act_row_loader.sv
// tb/tb_tpu_act_row_loader.sv - directed table-driven bench for tpu_act_row_loader
module tb_tpu_act_row_loader;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [15:0]   cmd_base_addr = '0;
    logic [8:0]    cmd_rows = '0;
    logic          cmd_swap = 1'b0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [15:0]   mem_req_addr;
    logic          mem_rsp_valid = 1'b0;
    logic          mem_rsp_ready;
    logic [63:0]   mem_rsp_data = '0;
    logic          unified_wr_en;
    logic [15:0]   unified_wr_addr;
    logic [127:0]  unified_wr_data;
    logic          swap_banks;
    logic          busy;
    logic          done;
    logic [8:0]    rows_loaded;

    tpu_act_row_loader dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base_addr(cmd_base_addr),
        .cmd_rows(cmd_rows), .cmd_swap(cmd_swap),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .unified_wr_en(unified_wr_en), .unified_wr_addr(unified_wr_addr),
        .unified_wr_data(unified_wr_data), .swap_banks(swap_banks), .busy(busy),
        .done(done), .rows_loaded(rows_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int lat = 1;
    logic tog = 1'b0;
    logic [15:0] gen = '0;
    int cyc = 0;
    logic [15:0] q_addr[$];
    int q_due[$];

    int acc = 0, acc_cyc = 0, done_cyc = 0, swap_cyc = 0;
    logic [15:0] m_base = '0;
    int m_row = 0, m_req = 0, m_rsp = 0;
    int n_wr = 0, n_req = 0, n_swap = 0, n_done = 0;
    int req_err = 0, wr_err = 0, proto_err = 0, max_out = 0, req_valid_cyc = 0;
    int last_wr_addr = 0;

    typedef struct {
        logic [15:0] base;
        logic [8:0]  rows;
        logic        swap;
        int          lat;
        logic        tog;
        int          exp_rows;
        int          exp_req;
        int          exp_swap;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [127:0] exp_row(logic [15:0] b, int r);
        logic [127:0] row;
        logic [15:0] a;
        row = '0;
        for (int k = 0; k < 2; k++) begin
            a = b + 16'(r * 2 + k);
            row[k*64 +: 64] = {gen, 32'h0, a};
        end
        return row;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic clear_counts();
        n_wr = 0; n_req = 0; n_swap = 0; n_done = 0;
        req_err = 0; wr_err = 0; max_out = 0; req_valid_cyc = 0; acc = 0;
    endtask

    task automatic issue(input logic [15:0] b, input logic [8:0] r, input logic s);
        int t;
        t = 0;
        while (!cmd_ready && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        cmd_base_addr = b; cmd_rows = r; cmd_swap = s; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (n_done < n && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Memory model and bus monitor share one per-cycle loop so handshakes are seen consistently.
    initial begin
        logic req_hs, rsp_hs, flush;
        logic [15:0] ra;
        forever begin
            @(negedge clk);
            flush  = !rst_n;
            req_hs = mem_req_valid && mem_req_ready;
            rsp_hs = mem_rsp_valid && mem_rsp_ready;
            ra     = mem_req_addr;
            if (rst_n && cmd_valid && cmd_ready) begin
                acc++; acc_cyc = cyc; m_base = cmd_base_addr; m_row = 0; m_req = 0; m_rsp = 0;
            end
            if (busy && cmd_ready) proto_err++;
            if (mem_req_valid) req_valid_cyc++;
            if (req_hs) begin
                if (ra !== m_base + 16'(m_req)) req_err++;
                m_req++; n_req++;
            end
            if (rsp_hs) m_rsp++;
            if (unified_wr_en) begin
                if (unified_wr_addr !== 16'(m_row) || unified_wr_data !== exp_row(m_base, m_row)) begin
                    if (wr_err == 0)
                        $display("FAIL wr_row%0d actual=%0h/%0h required=%0h/%0h", m_row,
                                 unified_wr_addr, unified_wr_data, 16'(m_row), exp_row(m_base, m_row));
                    wr_err++;
                end
                last_wr_addr = int'(unified_wr_addr);
                m_row++; n_wr++;
            end
            if (swap_banks) begin n_swap++; swap_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            @(posedge clk); #1;
            cyc++;
            if (flush) begin
                q_addr.delete(); q_due.delete();
            end else begin
                if (rsp_hs && q_addr.size() > 0) begin
                    void'(q_addr.pop_front()); void'(q_due.pop_front());
                end
                if (req_hs) begin
                    q_addr.push_back(ra); q_due.push_back(cyc + lat - 1);
                end
            end
            if (q_addr.size() > max_out) max_out = q_addr.size();
            mem_req_ready = tog ? cyc[0] : 1'b1;
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = {gen, 32'h0, q_addr[0]};
            end else begin
                mem_rsp_valid = 1'b0; mem_rsp_data = '0;
            end
        end
    end

    initial begin
        int t;
        vecs[0] = '{16'h0100, 9'd3,   1'b1, 1, 1'b0, 3,   6,   1};
        vecs[1] = '{16'h0100, 9'd3,   1'b0, 5, 1'b1, 3,   6,   0};
        vecs[2] = '{16'h0000, 9'd0,   1'b1, 1, 1'b0, 0,   0,   0};
        vecs[3] = '{16'hFFFE, 9'd300, 1'b1, 1, 1'b0, 256, 512, 1};
        vecs[4] = '{16'h1234, 9'd1,   1'b0, 2, 1'b1, 1,   2,   0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {57'h0, cmd_ready, busy, mem_req_valid, mem_rsp_ready,
                            unified_wr_en, swap_banks, done}, 64'b1000000);
        check("reset_rows", 64'(rows_loaded), 64'd0);
        check("reset_wdata", {63'h0, (unified_wr_data == '0 && unified_wr_addr == '0)}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            lat = vecs[i].lat; tog = vecs[i].tog;
            clear_counts();
            issue(vecs[i].base, vecs[i].rows, vecs[i].swap);
            wait_done(1);
            check($sformatf("v%0d_done", i), 64'(n_done), 64'd1);
            check($sformatf("v%0d_rows", i), 64'(rows_loaded), 64'(vecs[i].exp_rows));
            check($sformatf("v%0d_writes", i), 64'(n_wr), 64'(vecs[i].exp_rows));
            check($sformatf("v%0d_reqs", i), 64'(n_req), 64'(vecs[i].exp_req));
            check($sformatf("v%0d_swaps", i), 64'(n_swap), 64'(vecs[i].exp_swap));
            check($sformatf("v%0d_req_addr_errs", i), 64'(req_err), 64'd0);
            check($sformatf("v%0d_wr_errs", i), 64'(wr_err), 64'd0);
            check($sformatf("v%0d_outstanding_le4", i), 64'(max_out <= 4), 64'd1);
            check($sformatf("v%0d_idle", i), {62'h0, busy, cmd_ready}, 64'b01);
            if (vecs[i].exp_rows > 0)
                check($sformatf("v%0d_last_wr_addr", i), 64'(last_wr_addr), 64'(vecs[i].exp_rows - 1));
            else begin
                check($sformatf("v%0d_done_latency", i), 64'(done_cyc - acc_cyc), 64'd2);
                check($sformatf("v%0d_req_valid_cycles", i), 64'(req_valid_cyc), 64'd0);
            end
            if (vecs[i].exp_swap > 0)
                check($sformatf("v%0d_swap_to_done", i), 64'(done_cyc - swap_cyc), 64'd2);
        end

        // Reset after row 0 is written and beat 0 of row 1 is held.
        lat = 1; tog = 1'b0;
        clear_counts();
        issue(16'h0200, 9'd4, 1'b1);
        t = 0;
        while (m_rsp < 3 && t < 200) begin
            @(posedge clk); t++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_ctl", {57'h0, cmd_ready, busy, mem_req_valid, mem_rsp_ready,
                               unified_wr_en, swap_banks, done}, 64'b1000000);
        check("midreset_rows", 64'(rows_loaded), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        gen = 16'h00A5;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset_pulses", 64'(n_swap + n_done), 64'd0);
        clear_counts();
        issue(16'h0300, 9'd1, 1'b0);
        wait_done(1);
        check("fresh_writes", 64'(n_wr), 64'd1);
        check("fresh_wr_errs", 64'(wr_err), 64'd0);
        check("fresh_last_addr", 64'(last_wr_addr), 64'd0);

        // Command held across a busy period is taken once more only after IDLE.
        clear_counts();
        proto_err = 0;
        cmd_base_addr = 16'h0400; cmd_rows = 9'd2; cmd_swap = 1'b0; cmd_valid = 1'b1;
        t = 0;
        while (acc < 1 && t < 50) begin @(posedge clk); t++; end
        #1;
        cmd_base_addr = 16'h0500;
        t = 0;
        while (acc < 2 && t < 500) begin @(posedge clk); t++; end
        #1;
        cmd_valid = 1'b0;
        wait_done(2);
        repeat (4) @(posedge clk);
        #1;
        check("busy_accepts", 64'(acc), 64'd2);
        check("busy_writes", 64'(n_wr), 64'd4);
        check("busy_wr_errs", 64'(wr_err), 64'd0);
        check("busy_dones", 64'(n_done), 64'd2);
        check("busy_ready_while_busy", 64'(proto_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
